// File: rtl/img_uart_pkg.sv
// Shared state encoding and header constants for the image UART streamer.
package img_uart_pkg;

  typedef logic [2:0] streamer_state_t;

  localparam streamer_state_t S_IDLE    = 3'd0;
  localparam streamer_state_t S_HEADER  = 3'd1;
  localparam streamer_state_t S_FETCH   = 3'd2;
  localparam streamer_state_t S_SEND    = 3'd3;
  localparam streamer_state_t S_WAIT_TX = 3'd4;
  localparam streamer_state_t S_DONE    = 3'd5;

  localparam logic [7:0]  HEADER_SYNC  = 8'hA5;
  localparam int unsigned HEADER_BYTES = 3;

endpackage

// File: rtl/img_uart_streamer_uart_tx.sv
// 8N1 UART transmitter without reset; done_o is high whenever the line is idle.
module uart_tx #(
  parameter int unsigned CLOCKS_PER_BAUD = 50
) (
  input  logic       clk,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       tx
);

  localparam int unsigned CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  typedef logic [CW-1:0] baud_t;

  logic       busy;
  baud_t      baud_cnt;
  logic [3:0] bit_cnt;
  logic [9:0] frame;

  always_ff @(posedge clk) begin
    if (!busy) begin
      if (start_i) begin
        busy     <= 1'b1;
        frame    <= {1'b1, data_i, 1'b0};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == baud_t'(CLOCKS_PER_BAUD - 1)) begin
      baud_cnt <= '0;
      frame    <= {1'b1, frame[9:1]};
      bit_cnt  <= bit_cnt + 1'b1;
      if (bit_cnt == 4'd9) busy <= 1'b0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Idle level is derived from busy so power-up state reads as an idle line.
  assign done_o = ~busy;
  assign tx     = busy ? frame[0] : 1'b1;

endmodule

// File: rtl/img_uart_streamer.sv
// Streams a window of BRAM pixels (optionally preceded by a 3-byte header) over UART.
module img_uart_streamer #(
  parameter int unsigned BRAM_LENGTH     = 4096,
  parameter int unsigned BIT_DEPTH       = 8,
  parameter int unsigned BRAM_LATENCY    = 2,
  parameter int unsigned CLOCKS_PER_BAUD = 50,
  parameter int unsigned HEADER_EN       = 1,
  localparam int unsigned AW             = $clog2(BRAM_LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [AW-1:0]        base_addr_in,
  input  logic [AW:0]          count_in,
  input  logic                 abort_in,
  input  logic [BIT_DEPTH-1:0] data_in,
  output logic [AW-1:0]        addr_out,
  output logic                 tx_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 aborted_out
);
  import img_uart_pkg::*;

  localparam int unsigned BPP = (BIT_DEPTH + 7) / 8;
  localparam int unsigned SW  = BPP * 8;
  localparam int unsigned LW  = $clog2(BRAM_LATENCY + 1);
  localparam int unsigned BW  = $clog2(BPP + 1);

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [SW-1:0] shreg_t;
  typedef logic [LW-1:0] lat_t;
  typedef logic [BW-1:0] bidx_t;

  localparam cnt_t LEN = cnt_t'(BRAM_LENGTH);

  streamer_state_t state;
  addr_t           base;
  cnt_t            count, pix_idx, count_clamped;
  lat_t            lat_cnt;
  shreg_t          shreg;
  bidx_t           byte_idx;
  logic [1:0]      hdr_idx;
  logic            in_hdr, seen_low;
  logic [15:0]     count16;
  logic [7:0]      hdr_byte, tx_byte;
  logic            tx_start, tx_done;

  function automatic addr_t wrap_addr(input addr_t b, input cnt_t idx);
    cnt_t sum;
    sum = {1'b0, b} + idx;
    if (sum >= LEN) sum = sum - LEN;
    return sum[AW-1:0];
  endfunction

  always_comb begin
    count_clamped = (count_in > LEN) ? LEN : count_in;
    count16       = 16'(count);
    case (hdr_idx)
      2'd0:    hdr_byte = HEADER_SYNC;
      2'd1:    hdr_byte = count16[7:0];
      default: hdr_byte = count16[15:8];
    endcase
    tx_byte  = in_hdr ? hdr_byte : shreg[7:0];
    tx_start = (state == S_SEND) && tx_done;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state       <= S_IDLE;
      addr_out    <= '0;
      aborted_out <= 1'b0;
      base        <= '0;
      count       <= '0;
      pix_idx     <= '0;
      byte_idx    <= '0;
      hdr_idx     <= '0;
      lat_cnt     <= '0;
      shreg       <= '0;
      in_hdr      <= 1'b0;
      seen_low    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_in) begin
          base        <= base_addr_in;
          count       <= count_clamped;
          pix_idx     <= '0;
          byte_idx    <= '0;
          hdr_idx     <= '0;
          aborted_out <= 1'b0;
          in_hdr      <= (HEADER_EN != 0);
          if (HEADER_EN != 0) begin
            state <= S_HEADER;
          end else if (count_clamped == '0) begin
            state <= S_DONE;
          end else begin
            addr_out <= wrap_addr(base_addr_in, '0);
            lat_cnt  <= '0;
            state    <= S_FETCH;
          end
        end
        S_HEADER: begin
          if (abort_in) begin
            aborted_out <= 1'b1;
            state       <= S_DONE;
          end else begin
            state <= S_SEND;
          end
        end
        S_FETCH: begin
          if (lat_cnt == '0 && abort_in) begin
            aborted_out <= 1'b1;
            state       <= S_DONE;
          end else if (lat_cnt == lat_t'(BRAM_LATENCY)) begin
            shreg <= shreg_t'(data_in);
            state <= S_SEND;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_SEND: if (tx_done) begin
          seen_low <= 1'b0;
          state    <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          // Byte boundary is the low-then-high edge of done_o, not merely done_o high.
          if (!tx_done) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            if (abort_in) begin
              aborted_out <= 1'b1;
              state       <= S_DONE;
            end else if (in_hdr) begin
              if (hdr_idx == 2'(HEADER_BYTES - 1)) begin
                in_hdr <= 1'b0;
                if (count == '0) begin
                  state <= S_DONE;
                end else begin
                  addr_out <= wrap_addr(base, '0);
                  lat_cnt  <= '0;
                  state    <= S_FETCH;
                end
              end else begin
                hdr_idx <= hdr_idx + 1'b1;
                state   <= S_HEADER;
              end
            end else begin
              shreg <= shreg >> 8;
              if (byte_idx != bidx_t'(BPP - 1)) begin
                byte_idx <= byte_idx + 1'b1;
                state    <= S_SEND;
              end else if (pix_idx + 1'b1 == count) begin
                state <= S_DONE;
              end else begin
                pix_idx  <= pix_idx + 1'b1;
                byte_idx <= '0;
                addr_out <= wrap_addr(base, pix_idx + 1'b1);
                lat_cnt  <= '0;
                state    <= S_FETCH;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_out = (state != S_IDLE) && (state != S_DONE);
  assign done_out = (state == S_DONE);

  uart_tx #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_uart_tx (
    .clk     (clk),
    .data_i  (tx_byte),
    .start_i (tx_start),
    .done_o  (tx_done),
    .tx      (tx_out)
  );

endmodule
